// File: rtl/clock_time_ctrl.sv
// Wall-clock timekeeping with a button-driven set mode (hour, minute, second).
// Time advances on en1hz while running; set mode blanks the field being edited and auto-exits after inactivity.
module clock_time_ctrl #(
  parameter int unsigned HOUR_MAX  = 23,
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en1hz,
  input  logic       sig2hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       cnt_clr,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       setting,
  output logic       blank_hour,
  output logic       blank_min,
  output logic       blank_sec
);

  localparam logic [4:0] HMAX     = 5'(HOUR_MAX);
  localparam logic [5:0] TMO_LAST = 6'(TIMEOUT_S - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] tmo_q, tmo_d;
  logic       cnt_clr_q, cnt_clr_d;
  logic       prev_mode_q, prev_inc_q;
  logic       mode_ev, inc_ev;

  assign mode_ev = btn_mode & ~prev_mode_q;
  assign inc_ev  = btn_inc & ~prev_inc_q;

  always_comb begin
    state_d   = state_q;
    hour_d    = hour_q;
    min_d     = min_q;
    sec_d     = sec_q;
    tmo_d     = tmo_q;
    cnt_clr_d = 1'b0;

    if (state_q == RUN) begin
      // Tick is applied even when mode_ev leaves RUN in the same cycle.
      if (en1hz) begin
        if (sec_q == 6'd59) begin
          sec_d = '0;
          if (min_q == 6'd59) begin
            min_d  = '0;
            hour_d = (hour_q == HMAX) ? '0 : hour_q + 5'd1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end
      if (mode_ev) begin
        state_d = SET_HOUR;
        tmo_d   = '0;
      end
    end else if (mode_ev) begin
      tmo_d = '0;
      unique case (state_q)
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        default: begin
          state_d   = RUN;
          cnt_clr_d = 1'b1;
        end
      endcase
    end else if (inc_ev) begin
      tmo_d = '0;
      unique case (state_q)
        SET_HOUR: hour_d = (hour_q == HMAX) ? '0 : hour_q + 5'd1;
        SET_MIN:  min_d  = (min_q == 6'd59) ? '0 : min_q + 6'd1;
        default:  sec_d  = '0;
      endcase
    end else if (en1hz) begin
      if (tmo_q == TMO_LAST) begin
        state_d   = RUN;
        cnt_clr_d = 1'b1;
        tmo_d     = '0;
      end else begin
        tmo_d = tmo_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      tmo_q       <= '0;
      cnt_clr_q   <= 1'b0;
      prev_mode_q <= 1'b1;
      prev_inc_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      tmo_q       <= tmo_d;
      cnt_clr_q   <= cnt_clr_d;
      prev_mode_q <= btn_mode;
      prev_inc_q  <= btn_inc;
    end
  end

  assign hour       = hour_q;
  assign min        = min_q;
  assign sec        = sec_q;
  assign cnt_clr    = cnt_clr_q;
  assign setting    = (state_q != RUN);
  assign blank_hour = (state_q == SET_HOUR) & ~sig2hz;
  assign blank_min  = (state_q == SET_MIN) & ~sig2hz;
  assign blank_sec  = (state_q == SET_SEC) & ~sig2hz;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with hand-computed expectations (TIMEOUT_S = 3).
module tb_clock_time_ctrl;

  logic       clk, rst, en1hz, sig2hz, btn_mode, btn_inc;
  logic       cnt_clr, setting, blank_hour, blank_min, blank_sec;
  logic [4:0] hour;
  logic [5:0] min, sec;

  int n_checks = 0;
  int n_fail   = 0;

  clock_time_ctrl #(.HOUR_MAX(23), .TIMEOUT_S(3)) dut (
    .clk(clk), .rst(rst), .en1hz(en1hz), .sig2hz(sig2hz),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .cnt_clr(cnt_clr),
    .hour(hour), .min(min), .sec(sec), .setting(setting),
    .blank_hour(blank_hour), .blank_min(blank_min), .blank_sec(blank_sec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; step();
    btn_mode = 1'b0; step();
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      btn_inc = 1'b1; step();
      btn_inc = 1'b0; step();
    end
  endtask

  task automatic pulse_1hz(input int n);
    for (int i = 0; i < n; i++) begin
      en1hz = 1'b1; step();
      en1hz = 1'b0; step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en1hz = 1'b0; sig2hz = 1'b1; btn_mode = 1'b1; btn_inc = 1'b1;
    #12;
    n_checks++;
    if ({hour, min, sec} !== 17'd0) begin
      n_fail++; $display("FAIL reset_time: got %0d:%0d:%0d expected 0:0:0", hour, min, sec);
    end
    n_checks++;
    if ({setting, cnt_clr, blank_hour, blank_min, blank_sec} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {setting, cnt_clr, blank_hour, blank_min, blank_sec});
    end
    @(negedge clk); rst = 1'b0;
    step(); step(); step();
    n_checks++;
    if ({setting, cnt_clr} !== 2'b00) begin
      n_fail++; $display("FAIL held_btn_no_edge: got setting/cnt_clr %b expected 00", {setting, cnt_clr});
    end
    btn_mode = 1'b0; btn_inc = 1'b0; step();
    sig2hz = 1'b0; #1;
    n_checks++;
    if ({blank_hour, blank_min, blank_sec} !== 3'b000) begin
      n_fail++; $display("FAIL run_no_blank: got %b expected 000", {blank_hour, blank_min, blank_sec});
    end
    sig2hz = 1'b1;
  endtask

  task automatic test_rollover();
    press_mode(); press_inc(23);
    n_checks++;
    if (hour !== 5'd23) begin n_fail++; $display("FAIL set_hour23: got %0d expected 23", hour); end
    press_mode(); press_inc(58);
    press_mode(); press_inc(1);
    press_mode();
    n_checks++;
    if ({setting, hour, min, sec} !== {1'b0, 5'd23, 6'd58, 6'd0}) begin
      n_fail++; $display("FAIL preload: got set=%b %0d:%0d:%0d expected set=0 23:58:0", setting, hour, min, sec);
    end
    pulse_1hz(60);
    n_checks++;
    if ({hour, min, sec} !== {5'd23, 6'd59, 6'd0}) begin
      n_fail++; $display("FAIL min_carry: got %0d:%0d:%0d expected 23:59:0", hour, min, sec);
    end
    pulse_1hz(59);
    n_checks++;
    if ({hour, min, sec} !== {5'd23, 6'd59, 6'd59}) begin
      n_fail++; $display("FAIL at_235959: got %0d:%0d:%0d expected 23:59:59", hour, min, sec);
    end
    en1hz = 1'b1; step(); en1hz = 1'b0;
    n_checks++;
    if ({hour, min, sec} !== 17'd0) begin
      n_fail++; $display("FAIL day_wrap: got %0d:%0d:%0d expected 0:0:0", hour, min, sec);
    end
    step();
  endtask

  task automatic test_set_min();
    press_mode(); press_inc(2);
    press_mode(); press_inc(59);
    n_checks++;
    if (min !== 6'd59) begin n_fail++; $display("FAIL set_min59: got %0d expected 59", min); end
    press_inc(1);
    n_checks++;
    if ({hour, min} !== {5'd2, 6'd0}) begin
      n_fail++; $display("FAIL min_wrap_no_carry: got %0d:%0d expected 2:0", hour, min);
    end
    sig2hz = 1'b1; #1;
    n_checks++;
    if ({blank_hour, blank_min, blank_sec} !== 3'b000) begin
      n_fail++; $display("FAIL blank_visible: got %b expected 000", {blank_hour, blank_min, blank_sec});
    end
    sig2hz = 1'b0; #1;
    n_checks++;
    if ({blank_hour, blank_min, blank_sec} !== 3'b010) begin
      n_fail++; $display("FAIL blank_min_phase: got %b expected 010", {blank_hour, blank_min, blank_sec});
    end
    sig2hz = 1'b1;
  endtask

  task automatic test_set_sec();
    press_mode(); press_mode();
    pulse_1hz(37);
    n_checks++;
    if ({hour, min, sec} !== {5'd2, 6'd0, 6'd37}) begin
      n_fail++; $display("FAIL run_to_37: got %0d:%0d:%0d expected 2:0:37", hour, min, sec);
    end
    press_mode(); press_mode(); press_mode();
    pulse_1hz(2);
    n_checks++;
    if ({setting, hour, min, sec} !== {1'b1, 5'd2, 6'd0, 6'd37}) begin
      n_fail++; $display("FAIL frozen_in_set: got set=%b %0d:%0d:%0d expected set=1 2:0:37", setting, hour, min, sec);
    end
    press_inc(1);
    n_checks++;
    if (sec !== 6'd0) begin n_fail++; $display("FAIL sec_clear: got %0d expected 0", sec); end
    btn_mode = 1'b1; step();
    n_checks++;
    if ({setting, cnt_clr} !== 2'b01) begin
      n_fail++; $display("FAIL exit_clr_pulse: got setting/cnt_clr %b expected 01", {setting, cnt_clr});
    end
    btn_mode = 1'b0; step();
    n_checks++;
    if (cnt_clr !== 1'b0) begin n_fail++; $display("FAIL clr_one_cycle: got %b expected 0", cnt_clr); end
  endtask

  task automatic test_timeout();
    press_mode();
    pulse_1hz(2);
    n_checks++;
    if (setting !== 1'b1) begin n_fail++; $display("FAIL before_timeout: got %b expected 1", setting); end
    en1hz = 1'b1; step(); en1hz = 1'b0;
    n_checks++;
    if ({setting, cnt_clr} !== 2'b01) begin
      n_fail++; $display("FAIL timeout_exit: got setting/cnt_clr %b expected 01", {setting, cnt_clr});
    end
    step();
    n_checks++;
    if ({cnt_clr, hour, min, sec} !== {1'b0, 5'd2, 6'd0, 6'd0}) begin
      n_fail++; $display("FAIL timeout_after: got clr=%b %0d:%0d:%0d expected clr=0 2:0:0", cnt_clr, hour, min, sec);
    end
    press_mode();
    pulse_1hz(2);
    press_inc(1);
    pulse_1hz(2);
    n_checks++;
    if ({setting, hour} !== {1'b1, 5'd3}) begin
      n_fail++; $display("FAIL inc_restarts_timeout: got set=%b hour=%0d expected set=1 hour=3", setting, hour);
    end
    en1hz = 1'b1; step(); en1hz = 1'b0;
    n_checks++;
    if ({setting, cnt_clr} !== 2'b01) begin
      n_fail++; $display("FAIL timeout_exit2: got setting/cnt_clr %b expected 01", {setting, cnt_clr});
    end
    step();
  endtask

  task automatic test_simultaneous();
    press_mode(); press_inc(2);
    btn_mode = 1'b1; btn_inc = 1'b1; step();
    btn_mode = 1'b0; btn_inc = 1'b0; step();
    sig2hz = 1'b0; #1;
    n_checks++;
    if ({hour, blank_hour, blank_min, setting} !== {5'd5, 1'b0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL mode_beats_inc: got hour=%0d bh/bm/set=%b expected hour=5 bh/bm/set=011", hour, {blank_hour, blank_min, setting});
    end
    sig2hz = 1'b1;
    @(negedge clk); rst = 1'b1; #1;
    n_checks++;
    if ({setting, cnt_clr, hour, min, sec} !== 19'd0) begin
      n_fail++; $display("FAIL reset_mid_set: got set=%b clr=%b %0d:%0d:%0d expected 0 0 0:0:0", setting, cnt_clr, hour, min, sec);
    end
    @(negedge clk); rst = 1'b0;
    step(); step();
    en1hz = 1'b1; btn_mode = 1'b1; step();
    en1hz = 1'b0; btn_mode = 1'b0;
    n_checks++;
    if ({setting, hour, min, sec} !== {1'b1, 5'd0, 6'd0, 6'd1}) begin
      n_fail++; $display("FAIL tick_with_mode: got set=%b %0d:%0d:%0d expected set=1 0:0:1", setting, hour, min, sec);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_set_min();
    test_set_sec();
    test_timeout();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
